// File: rtl/par2ser_pkg.sv
// Shared types for the parallel-to-serial feeder.
package par2ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } ser_state_t;

endpackage

// File: rtl/par2ser_feeder.sv
// par2ser_feeder: WIDTH-bit words in on valid/ready, one registered bit per cycle out on X.
// Build option SER_PARITY_EN appends an even-parity bit after each word's data bits.
module par2ser_feeder
  import par2ser_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             Clock,
  input  logic             Clr,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_Valid,
  output logic             Din_Ready,
  output logic             X,
  output logic             X_Valid,
  output logic             Busy
);
  // state  | meaning
  // IDLE   | no word in flight, X at IDLE_LEVEL, ready for a new word
  // SHIFT  | data bit r_cnt of the current word is on X
  // PARITY | even-parity bit of the current word is on X

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_x, w_x_nxt;
  logic             r_xv, w_xv_nxt;
  logic             r_busy;
  logic             w_last, w_ready, w_accept;
`ifdef SER_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  // r_shift holds only the bits still to be sent; the bit on X has already been removed.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign w_last = (r_cnt == LAST);
`ifdef SER_PARITY_EN
  assign w_ready = (r_state == IDLE) || (r_state == PARITY);
`else
  assign w_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_last);
`endif
  assign Din_Ready = w_ready & ~Clr;
  assign w_accept  = Din_Valid & Din_Ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_x_nxt     = r_x;
    w_xv_nxt    = r_xv;
`ifdef SER_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = '0;
      w_shift_nxt = drop(Din);
      w_x_nxt     = head(Din);
      w_xv_nxt    = 1'b1;
`ifdef SER_PARITY_EN
      w_par_nxt   = ^Din;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (!w_last) begin
            w_cnt_nxt   = r_cnt + CW'(1);
            w_shift_nxt = drop(r_shift);
            w_x_nxt     = head(r_shift);
            w_xv_nxt    = 1'b1;
          end else begin
`ifdef SER_PARITY_EN
            w_state_nxt = PARITY;
            w_x_nxt     = r_par;
            w_xv_nxt    = 1'b1;
`else
            w_state_nxt = IDLE;
            w_x_nxt     = IDLE_LEVEL;
            w_xv_nxt    = 1'b0;
`endif
          end
        end
        default: begin
          // PARITY without accept, IDLE, and any unreachable encoding all settle to idle
          w_state_nxt = IDLE;
          w_x_nxt     = IDLE_LEVEL;
          w_xv_nxt    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_x     <= IDLE_LEVEL;
      r_xv    <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_x     <= w_x_nxt;
      r_xv    <= w_xv_nxt;
      r_busy  <= (w_state_nxt != IDLE);
`ifdef SER_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign X       = r_x;
  assign X_Valid = r_xv;
  assign Busy    = r_busy;

endmodule

// File: tb/tb_par2ser_feeder.sv
// Bench for par2ser_feeder: MSB-first and LSB-first instances checked every cycle against a
// bit-queue model, plus literal captures of the serial stream for directed words.
module tb_par2ser_feeder;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int WL = PAR ? W + 1 : W;

  logic         Clock = 1'b0;
  logic         Clr = 1'b1;
  logic         Din_Valid = 1'b0;
  logic [W-1:0] Din = '0;
  logic         X_m, Xv_m, Busy_m, Rdy_m;
  logic         X_l, Xv_l, Busy_l, Rdy_l;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  par2ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
    .Clock(Clock), .Clr(Clr), .Din(Din), .Din_Valid(Din_Valid),
    .Din_Ready(Rdy_m), .X(X_m), .X_Valid(Xv_m), .Busy(Busy_m)
  );

  par2ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .Clock(Clock), .Clr(Clr), .Din(Din), .Din_Valid(Din_Valid),
    .Din_Ready(Rdy_l), .X(X_l), .X_Valid(Xv_l), .Busy(Busy_l)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of bits still owed on X; the head is the bit on X this cycle.
  bit q_m[$];
  bit q_l[$];
  bit m_acc;
  always @(posedge Clock) begin
    if (Clr) begin
      q_m.delete();
      q_l.delete();
    end else begin
      m_acc = Din_Valid && (q_m.size() <= 1);
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (m_acc) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back(Din[W-1-i]);
          q_l.push_back(Din[i]);
        end
        if (PAR) begin
          q_m.push_back(^Din);
          q_l.push_back(^Din);
        end
      end
    end
  end

  logic [31:0] cap_m = '0, cap_l = '0;
  int run_m = 0, max_run_m = 0;
  always @(negedge Clock) begin
    chk("m_xvalid", 32'(Xv_m),   32'(q_m.size() > 0));
    chk("m_x",      32'(X_m),    32'(q_m.size() > 0 ? q_m[0] : 1'b0));
    chk("m_busy",   32'(Busy_m), 32'(q_m.size() > 0));
    chk("m_ready",  32'(Rdy_m),  32'(!Clr && q_m.size() <= 1));
    chk("l_xvalid", 32'(Xv_l),   32'(q_l.size() > 0));
    chk("l_x",      32'(X_l),    32'(q_l.size() > 0 ? q_l[0] : 1'b1));
    chk("l_busy",   32'(Busy_l), 32'(q_l.size() > 0));
    chk("l_ready",  32'(Rdy_l),  32'(!Clr && q_l.size() <= 1));
    if (Xv_m === 1'b1) begin
      cap_m = {cap_m[30:0], X_m};
      run_m++;
      if (run_m > max_run_m) max_run_m = run_m;
    end else begin
      run_m = 0;
    end
    if (Xv_l === 1'b1) cap_l = {cap_l[30:0], X_l};
  end

  function automatic logic [31:0] w1(input logic [7:0] a, input logic pa);
    return PAR ? {23'b0, a, pa} : {24'b0, a};
  endfunction

  function automatic logic [31:0] w2(input logic [7:0] a, input logic pa,
                                     input logic [7:0] b, input logic pb);
    return PAR ? {14'b0, a, pa, b, pb} : {16'b0, a, b};
  endfunction

  function automatic logic [31:0] msk(input int nwords);
    return (32'd1 << (nwords * WL)) - 32'd1;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [W-1:0] d);
    Din = d;
    Din_Valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Rdy_m === 1'b1) begin
        tick();
        Din_Valid = 1'b0;
        Din = W'($urandom);
        return;
      end
      tick();
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: word %0h never accepted", d);
    Din_Valid = 1'b0;
  endtask

  task automatic clear_caps();
    cap_m = '0;
    cap_l = '0;
    max_run_m = 0;
  endtask

  int rdy_cnt;
  int k;
  logic [W-1:0] words [2];

  initial begin
    // reset held two cycles, then released
    tick();
    tick();
    chk("rst_ready", 32'(Rdy_m), 32'd0);
    chk("rst_x", 32'(X_m), 32'd0);
    chk("rst_xvalid", 32'(Xv_m), 32'd0);
    chk("rst_busy", 32'(Busy_m), 32'd0);
    chk("rst_lsb_idle_level", 32'(X_l), 32'd1);
    Clr = 1'b0;
    #1;
    chk("rel_ready", 32'(Rdy_m), 32'd1);
    tick();

    // single word
    clear_caps();
    send(8'hA5);
    idle(WL + 1);
    chk("a5_msb_stream", cap_m & msk(1), w1(8'hA5, 1'b0));
    chk("a5_lsb_stream", cap_l & msk(1), w1(8'hA5, 1'b0));
    chk("a5_bits", 32'(max_run_m), 32'(WL));
    chk("a5_done_xvalid", 32'(Xv_m), 32'd0);
    chk("a5_done_busy", 32'(Busy_m), 32'd0);

    // back-to-back with Din_Valid held across the boundary
    clear_caps();
    send(8'hA5);
    send(8'h3C);
    idle(2 * WL + 2);
    chk("b2b_stream", cap_m & msk(2), w2(8'hA5, 1'b0, 8'h3C, 1'b0));
    chk("b2b_no_gap", 32'(max_run_m), 32'(2 * WL));

    // valid held throughout with garbage on Din mid-word
    clear_caps();
    words[0] = 8'hC3;
    words[1] = 8'h96;
    rdy_cnt = 0;
    k = 0;
    Din_Valid = 1'b1;
    for (int i = 0; i <= 2 * WL; i++) begin
      if (Rdy_m === 1'b1) begin
        rdy_cnt++;
        if (k < 2) begin
          Din = words[k];
          k++;
        end else begin
          Din_Valid = 1'b0;
        end
      end else begin
        Din = W'($urandom);
      end
      tick();
    end
    Din_Valid = 1'b0;
    idle(3);
    chk("stall_ready_cycles", 32'(rdy_cnt), 32'd3);
    chk("stall_stream", cap_m & msk(2), w2(8'hC3, 1'b0, 8'h96, 1'b0));
    chk("stall_no_gap", 32'(max_run_m), 32'(2 * WL));

    // Clr while bit 3 of 8'hFF is on X
    send(8'hFF);
    idle(3);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    chk("clr_xvalid", 32'(Xv_m), 32'd0);
    chk("clr_busy", 32'(Busy_m), 32'd0);
    idle(2);
    chk("clr_stays_idle", 32'(Xv_m), 32'd0);
    clear_caps();
    send(8'h01);
    idle(WL + 1);
    chk("after_clr_msb", cap_m & msk(1), w1(8'h01, 1'b1));
    chk("after_clr_lsb", cap_l & msk(1), w1(8'h80, 1'b1));

    if (PAR) begin
      clear_caps();
      send(8'h07);
      idle(WL + 1);
      chk("par_07", cap_m & msk(1), w1(8'h07, 1'b1));
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
